// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory-control bit positions, data-cache FSM states,
// and the registered backing-memory request bundle.
package mips_pkg;

    localparam int MEM_BRANCH = 2;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RMISS = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } dc_state_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped valid/tag/data storage: combinational read, synchronous write, synchronous valid clear.
// Write and read ports are independent; clear overrides a same-cycle write.
module dcache_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  clr_vld,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_vld,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [31:0]           rd_dat,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_dat
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    valid_d;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_vld) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data contents are don't-care while the line is invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en && !clr_vld) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_vld = valid_q[rd_idx];
    assign rd_tag = tag_mem[rd_idx];
    assign rd_dat = data_mem[rd_idx];

endmodule

// File: rtl/mem_stage_dcache.sv
// MEM-stage write-through, no-write-allocate data cache; load hit returns data the same cycle.
// Misses and stores stall the pipeline (hit=0) until the backing-memory ack plus one DONE cycle.
module mem_stage_dcache
    import mips_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ctlmem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int TAG_BITS = 30 - INDEX_BITS;

    dc_state_e state_q, state_d;
    mem_req_t  req_q, req_d;
    logic [31:0] result_q, result_d;

    logic                  is_rd, is_wr;
    logic [INDEX_BITS-1:0] cur_idx;
    logic [TAG_BITS-1:0]   cur_tag;
    logic                  arr_vld;
    logic [TAG_BITS-1:0]   arr_tag;
    logic [31:0]           arr_dat;
    logic                  tag_match;
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [31:0]           wr_dat;
    logic                  unused_ok;

    assign is_rd     = ctlmem[MEM_READ];
    assign is_wr     = ctlmem[MEM_WRITE];
    assign cur_idx   = addr[INDEX_BITS+1:2];
    assign cur_tag   = addr[31:INDEX_BITS+2];
    assign tag_match = arr_vld && (arr_tag == cur_tag);
    assign unused_ok = ^{ctlmem[MEM_BRANCH], addr[1:0]};

    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk     (clk),
        .clr_vld (rst),
        .rd_idx  (cur_idx),
        .rd_vld  (arr_vld),
        .rd_tag  (arr_tag),
        .rd_dat  (arr_dat),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_tag  (wr_tag),
        .wr_dat  (wr_dat)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        result_d = result_q;
        wr_en    = 1'b0;
        wr_idx   = cur_idx;
        wr_tag   = cur_tag;
        wr_dat   = wdata;
        hit      = 1'b0;
        rdata    = '0;
        case (state_q)
            ST_IDLE: begin
                if (is_wr) begin
                    // Store wins over a simultaneous read; only an already-resident line is updated.
                    wr_en       = tag_match;
                    req_d.req   = 1'b1;
                    req_d.we    = 1'b1;
                    req_d.addr  = word_align(addr);
                    req_d.wdata = wdata;
                    result_d    = '0;
                    state_d     = ST_WRITE;
                end else if (is_rd && !tag_match) begin
                    req_d.req  = 1'b1;
                    req_d.we   = 1'b0;
                    req_d.addr = word_align(addr);
                    state_d    = ST_RMISS;
                end else begin
                    hit   = 1'b1;
                    rdata = is_rd ? arr_dat : '0;
                end
            end
            ST_RMISS: begin
                if (mem_ack) begin
                    wr_en     = 1'b1;
                    wr_idx    = req_q.addr[INDEX_BITS+1:2];
                    wr_tag    = req_q.addr[31:INDEX_BITS+2];
                    wr_dat    = mem_rdata;
                    result_d  = mem_rdata;
                    req_d.req = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    req_d.req = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                hit     = 1'b1;
                rdata   = result_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            result_q <= result_d;
        end
    end

    assign mem_req   = req_q.req;
    assign mem_we    = req_q.we;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Bench for mem_stage_dcache: directed scenarios plus random ops checked against a line/tag model
// and a backing-memory array that the bench also serves requests from.
module tb_mem_stage_dcache;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  ctlmem;
    logic [31:0] addr, wdata, rdata;
    logic        hit, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    bit          m_vld [64];
    logic [23:0] m_tag [64];
    logic [31:0] bmem [logic [31:0]];

    mem_stage_dcache #(.INDEX_BITS(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctlmem    (ctlmem),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .hit       (hit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
    endfunction

    // Called just after a posedge; returns just after the posedge that completes the op.
    task automatic do_op(input bit br, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int dly, input string nm);
        logic [31:0] wa, got_rd, exp_rd, req_addr, req_wdata;
        logic        req_we;
        int          idx, stalls, reqc, cyc;
        bit          cached, exp_stall, done;
        wa        = {a[31:2], 2'b00};
        idx       = int'(a[7:2]);
        cached    = m_vld[idx] && (m_tag[idx] == a[31:8]);
        exp_stall = wr || (rd && !cached);
        exp_rd    = (rd && !wr) ? memval(wa) : 32'h0;
        stalls = 0; reqc = 0; cyc = 0; done = 0;
        req_we = 1'bx; req_addr = 'x; req_wdata = 'x; got_rd = 'x;
        ctlmem = {br, rd, wr};
        addr   = a;
        wdata  = wd;
        while (!done && cyc < 60) begin
            @(negedge clk);
            mem_rdata = $urandom;
            if (mem_req) begin
                if (reqc == dly) begin
                    mem_ack   = 1'b1;
                    req_we    = mem_we;
                    req_addr  = mem_addr;
                    req_wdata = mem_wdata;
                    if (!mem_we) mem_rdata = memval(mem_addr);
                end
                reqc++;
            end
            if (hit) begin
                got_rd = rdata;
                done   = 1'b1;
            end else begin
                stalls++;
            end
            cyc++;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
        ctlmem = 3'b000;
        wdata  = $urandom;
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_stalls"}, stalls, exp_stall ? dly + 2 : 0);
        chk({nm, "_reqcyc"}, reqc, exp_stall ? dly + 1 : 0);
        chk({nm, "_rdata"}, got_rd, exp_rd);
        if (exp_stall) begin
            chk({nm, "_we"}, 32'(req_we), 32'(wr));
            chk({nm, "_maddr"}, req_addr, wa);
            if (wr) chk({nm, "_mwdata"}, req_wdata, wd);
        end
        if (wr) begin
            bmem[wa] = wd;
        end else if (rd && !cached) begin
            m_vld[idx] = 1'b1;
            m_tag[idx] = a[31:8];
        end
    endtask

    task automatic idle_cycle();
        ctlmem = 3'b000;
        addr   = $urandom;
        @(negedge clk);
        chk("idle_hit", 32'(hit), 32'd1);
        chk("idle_rdata", rdata, 32'h0);
        chk("idle_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ctlmem = 3'b000; addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_hit", 32'(hit), 32'd1);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mwdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1;

        bmem[32'h40] = 32'hDEAD_BEEF;
        do_op(0, 1, 0, 32'h40, 0, 2, "cold_miss");
        do_op(0, 1, 0, 32'h40, 0, 0, "rehit");
        do_op(0, 1, 0, 32'h140, 0, 1, "evict");
        do_op(0, 1, 0, 32'h40, 0, 0, "remiss");
        do_op(0, 0, 1, 32'h40, 32'h1234_5678, 1, "st_hit");
        do_op(0, 1, 0, 32'h40, 0, 0, "ld_after_st");
        do_op(0, 0, 1, 32'h80, 32'hCAFE_0080, 0, "st_miss");
        do_op(0, 1, 0, 32'h80, 0, 0, "no_alloc");
        idle_cycle();

        // Reset during the second RMISS cycle abandons the refill.
        ctlmem = 3'b010; addr = 32'h140;
        @(negedge clk);
        chk("ab_detect_hit", 32'(hit), 32'd0);
        chk("ab_detect_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ab_rmiss1_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ab_rmiss2_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; ctlmem = 3'b000;
        model_clear();
        @(negedge clk);
        chk("ab_req_drop", 32'(mem_req), 32'd0);
        chk("ab_idle_hit", 32'(hit), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_hit", 32'(hit), 32'd1);
        chk("late_ack_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        do_op(0, 1, 0, 32'h40, 0, 0, "post_rst_miss");
        do_op(0, 1, 1, 32'h40, 32'h0BAD_F00D, 1, "rdwr_store");
        do_op(0, 1, 0, 32'h40, 0, 0, "rdwr_ld");

        for (int n = 0; n < 300; n++) begin
            logic [23:0] t;
            logic [5:0]  ix;
            logic [31:0] a;
            int          k;
            t  = 24'($urandom_range(0, 3)) | ($urandom_range(0, 1) ? 24'h80_0000 : 24'h0);
            ix = 6'($urandom_range(0, 3));
            a  = {t, ix, 2'($urandom_range(0, 3))};
            k  = $urandom_range(0, 9);
            do_op(1'($urandom_range(0, 1)), k != 6 && k != 7 && k != 8, k >= 6, a,
                  $urandom, $urandom_range(0, 3), "rnd");
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
